// File: rtl/param_core.sv
// Multi-cycle register-file ALU core: each accepted instruction walks
// IDLE -> LOAD -> EXEC -> WB, writing back and pulsing done on the edge leaving WB.
module param_core #(
  parameter int DATA_W  = 16,
  parameter int NREG    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               run,
  output logic [DATA_W-1:0]  d_out,
  output logic               done,
  output logic               busy,
  output logic [2:0]         flags
);

  localparam int RA_W = $clog2(NREG);
  localparam logic [DATA_W-1:0] DW_L = DATA_W'(DATA_W);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, WB} state_e;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MOV} op_e;
  typedef enum logic [1:0] {FMT_REG, FMT_IMM, FMT_NOP, FMT_ILL} fmt_e;

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [DATA_W-1:0]  res_q, res_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic [2:0]         rflg_q, rflg_d;
  logic [2:0]         flags_q, flags_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [DATA_W-1:0]  regs_q [NREG];
  logic [DATA_W-1:0]  regs_d [NREG];

  logic [RA_W-1:0]    rx, ry;
  op_e                op;
  fmt_e               fmt;
  logic [DATA_W-1:0]  imm;
  logic [DATA_W:0]    sum, diff;
  logic [DATA_W-1:0]  shamt;
  logic [DATA_W-1:0]  alu_res;
  logic               alu_c;

  // imm shares its upper bits with Ry; the size cast zero-extends or truncates
  assign rx  = ir_q[INSTR_W-1 -: RA_W];
  assign ry  = ir_q[INSTR_W-RA_W-1 -: RA_W];
  assign op  = op_e'(ir_q[4:2]);
  assign fmt = fmt_e'(ir_q[1:0]);
  assign imm = DATA_W'(ir_q[INSTR_W-RA_W-1:5]);

  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    shamt   = b_q % DW_L;
    alu_res = b_q;
    alu_c   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      OP_SUB: begin
        alu_res = diff[DATA_W-1:0];
        alu_c   = diff[DATA_W];
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SHL: alu_res = a_q << shamt;
      OP_SHR: alu_res = a_q >> shamt;
      OP_MOV: alu_res = b_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    rflg_d  = rflg_q;
    dout_d  = dout_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    regs_d  = regs_q;
    case (state_q)
      IDLE: begin
        if (run) begin
          ir_d    = instruction;
          state_d = LOAD;
        end
      end
      LOAD: begin
        a_d     = regs_q[rx];
        b_d     = (fmt == FMT_IMM) ? imm : regs_q[ry];
        state_d = EXEC;
      end
      EXEC: begin
        res_d = alu_res;
        if (fmt == FMT_REG || fmt == FMT_IMM) rflg_d = {1'b0, alu_c, alu_res == '0};
        else                                   rflg_d = {fmt == FMT_ILL, 2'b00};
        state_d = WB;
      end
      WB: begin
        if (fmt == FMT_REG || fmt == FMT_IMM) begin
          regs_d[rx] = res_q;
          dout_d     = res_q;
        end
        flags_d = rflg_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      rflg_q  <= '0;
      dout_q  <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      rflg_q  <= rflg_d;
      dout_q  <= dout_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      regs_q  <= regs_d;
    end
  end

  assign d_out = dout_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_param_core.sv
// Bench for param_core at default parameters: directed literal cases plus random
// traffic, all checked every cycle against an instruction-level model.
module tb_param_core;

  logic        clk;
  logic        reset;
  logic [15:0] instruction;
  logic        run;
  logic [15:0] d_out;
  logic        done;
  logic        busy;
  logic [2:0]  flags;

  int total;
  int bad;
  bit chk_en;

  // model state
  logic [15:0] m_r [8];
  int          m_cnt;
  logic [15:0] p_res;
  logic [2:0]  p_flags;
  bit          p_wr;
  int unsigned p_rx;
  logic [15:0] e_dout;
  logic [2:0]  e_flags;
  logic        e_done;
  logic        e_busy;

  param_core #(.DATA_W(16), .NREG(8), .INSTR_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .run         (run),
    .d_out       (d_out),
    .done        (done),
    .busy        (busy),
    .flags       (flags)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_cnt   = 0;
    p_res   = '0;
    p_flags = '0;
    p_wr    = 1'b0;
    p_rx    = 0;
    e_dout  = '0;
    e_flags = '0;
    e_done  = 1'b0;
    e_busy  = 1'b0;
  endtask

  task automatic model_accept(input logic [15:0] ins);
    int unsigned w, rx, ry, imm, op, fmt, a, b, r;
    bit c;
    w   = 32'(ins);
    rx  = (w >> 13) & 7;
    ry  = (w >> 10) & 7;
    imm = (w >> 5) & 255;
    op  = (w >> 2) & 7;
    fmt = w & 3;
    a   = 32'(m_r[rx]);
    b   = (fmt == 1) ? imm : 32'(m_r[ry]);
    c   = 1'b0;
    case (op)
      0: begin r = a + b; c = (r > 65535); r = r % 65536; end
      1: begin c = (a < b); r = (a + 65536 - b) % 65536; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a << (b % 16)) % 65536;
      6: r = a >> (b % 16);
      default: r = b;
    endcase
    p_rx = rx;
    if (fmt < 2) begin
      p_wr    = 1'b1;
      p_res   = 16'(r);
      p_flags = {1'b0, c, r == 0};
    end else begin
      p_wr    = 1'b0;
      p_res   = '0;
      p_flags = {fmt == 3, 2'b00};
    end
  endtask

  // instruction-level timing: accepted on edge 0, retired on edge 3
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        e_done = 1'b0;
        if (m_cnt == 0) begin
          if (run) begin
            model_accept(instruction);
            m_cnt = 1;
          end
        end else if (m_cnt == 3) begin
          if (p_wr) begin
            m_r[p_rx] = p_res;
            e_dout    = p_res;
          end
          e_flags = p_flags;
          e_done  = 1'b1;
          m_cnt   = 0;
        end else begin
          m_cnt++;
        end
        e_busy = (m_cnt != 0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge reset);
      model_clear();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("busy",  64'(busy),  64'(e_busy));
        chk("done",  64'(done),  64'(e_done));
        chk("d_out", 64'(d_out), 64'(e_dout));
        chk("flags", 64'(flags), 64'(e_flags));
      end
    end
  end

  // called just after a falling edge; returns on the falling edge after done
  task automatic run_one(input logic [15:0] ins, input logic [15:0] x_dout,
                         input logic [2:0] x_flags, input string nm);
    int lat;
    bit seen;
    instruction = ins;
    run         = 1'b1;
    lat         = 0;
    seen        = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        run         = 1'b0;
        instruction = 16'($urandom);
      end
      if (done) seen = 1'b1;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd4);
    chk({nm, "_dout"}, 64'(d_out), 64'(x_dout));
    chk({nm, "_flags"}, 64'(flags), 64'(x_flags));
    chk({nm, "_busy_at_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({nm, "_done_one_cycle"}, 64'(done), 64'd0);
    chk({nm, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [15:0] held_ins   [3];
    logic [15:0] held_dout  [3];
    logic [2:0]  held_flags [3];
    int dones, cyc, last, first;

    held_ins   = '{16'h4410, 16'h4079, 16'h6C08};
    held_dout  = '{16'hFFF8, 16'h1FFF, 16'h0000};
    held_flags = '{3'b000, 3'b000, 3'b001};

    total = 0;
    bad = 0;
    chk_en = 1'b0;
    clk = 1'b0;
    reset = 1'b1;
    run = 1'b0;
    instruction = '0;
    model_clear();
    #1 reset = 1'b0;
    #1;
    chk("reset_dout",  64'(d_out), 64'd0);
    chk("reset_flags", 64'(flags), 64'd0);
    chk("reset_done",  64'(done),  64'd0);
    chk("reset_busy",  64'(busy),  64'd0);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    run_one(16'h20BD, 16'h0005, 3'b000, "mov_r1_5");
    run_one(16'h3FE1, 16'h0104, 3'b000, "add_r1_ff");
    run_one(16'h4404, 16'hFEFC, 3'b010, "sub_r2_r1");
    run_one(16'h0003, 16'hFEFC, 3'b100, "illegal");

    // run held high: new word presented only when done, garbage otherwise
    instruction = held_ins[0];
    run   = 1'b1;
    dones = 0;
    cyc   = 0;
    last  = 0;
    first = 0;
    while (dones < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        chk("held_dout",  64'(d_out), 64'(held_dout[dones]));
        chk("held_flags", 64'(flags), 64'(held_flags[dones]));
        dones++;
        if (dones == 1) first = cyc;
        else chk("held_spacing", 64'(cyc - last), 64'd4);
        last = cyc;
        if (dones < 3) instruction = held_ins[dones];
        else run = 1'b0;
      end else begin
        instruction = 16'($urandom);
      end
    end
    chk("held_done_count", 64'(dones), 64'd3);
    chk("held_first_latency", 64'(first), 64'd4);

    repeat (300) begin
      @(negedge clk);
      run         = 1'($urandom_range(0, 1));
      instruction = 16'($urandom);
    end
    @(negedge clk);
    run = 1'b0;
    repeat (5) @(negedge clk);

    // reset while in EXEC aborts the instruction and clears the register file
    instruction = 16'h20BD;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_dout",  64'(d_out), 64'd0);
    chk("abort_flags", 64'(flags), 64'd0);
    chk("abort_busy",  64'(busy),  64'd0);
    chk("abort_done",  64'(done),  64'd0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    run_one(16'h441C, 16'h0000, 3'b001, "mov_r2_r1_after_reset");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_core.md
PARAM_CORE -- requirements
Module: param_core

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath and register width (8..64).
REQ-002 SHALL have parameter NREG, default 8, register count (power of two, 2..16); RA_W = log2(NREG).
REQ-003 SHALL have parameter INSTR_W, default 16, instruction width; INSTR_W >= 5 + 2*RA_W + 1.
REQ-004 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port instruction, input, INSTR_W, the instruction word, sampled only when an instruction is accepted.
REQ-007 SHALL have port run, input, 1, request to execute the presented instruction.
REQ-008 SHALL have port d_out, output, DATA_W, the last written-back result (registered).
REQ-009 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port busy, output, 1, high while an instruction is in flight.
REQ-011 SHALL have port flags, output, 3, {illegal, carry, zero} of the last completed instruction.

Function
REQ-012 SHALL use the instruction fields Rx = [INSTR_W-1 -: RA_W], Ry = [INSTR_W-RA_W-1 -: RA_W], op = [4:2], fmt = [1:0].
REQ-013 SHALL form imm from bits [INSTR_W-RA_W-1:5], zero-extended or truncated to DATA_W; the default imm is [12:5].
REQ-014 SHALL decode fmt as: 0 = register (B = R[Ry]), 1 = immediate (B = imm), 2 = NOP (no writeback), 3 = illegal (no writeback, illegal flag = 1).
REQ-015 SHALL decode op on A = R[Rx] as: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 MOV (result = B).
REQ-016 SHALL take the SHL/SHR shift amount as B mod DATA_W.
REQ-017 SHALL set carry to the ADD carry-out, or to the SUB borrow (1 when A < B unsigned), and to 0 for all other ops.
REQ-018 SHALL set zero = (result == 0) for a writeback instruction; for fmt 2 or 3 it SHALL set zero and carry to 0.
REQ-019 SHALL implement the FSM states IDLE, LOAD, EXEC and WB.
REQ-020 SHALL move IDLE->LOAD when run=1, capturing the instruction into the instruction register.
REQ-021 SHALL move LOAD->EXEC unconditionally, latching A and B from the register file and imm.
REQ-022 SHALL move EXEC->WB unconditionally, computing the result and flags into a result register.
REQ-023 SHALL move WB->IDLE unconditionally.
REQ-024 SHALL, on the edge leaving WB, write R[Rx] and d_out (fmt 0/1 only), update flags, and set done=1 for exactly one cycle.
REQ-025 SHALL give a latency of exactly 4 cycles from the edge sampling run=1 in IDLE to the cycle in which done=1.
REQ-026 SHALL give a maximum throughput of one instruction per 4 cycles when run is held high.
REQ-027 SHALL set busy = 1 in LOAD, EXEC and WB, and busy = 0 in IDLE.
REQ-028 SHALL ignore run while busy, and SHALL ignore changes on instruction after capture.
REQ-029 SHALL allow Rx == Ry; the operands are read in LOAD, before the writeback.
REQ-030 SHALL truncate all results to DATA_W bits; arithmetic SHALL wrap modulo 2^DATA_W.

Reset
REQ-031 SHALL, while reset = 0, immediately force: state = IDLE, all R[i] = 0, d_out = 0, done = 0, busy = 0, flags = 0.
REQ-032 SHALL, on reset mid-instruction, abort the instruction with no writeback and no done pulse.
REQ-033 SHALL accept a run request on the first rising clk edge after reset deasserts.

Verification (DATA_W=16, NREG=8, INSTR_W=16)
REQ-034 SHALL cover: reset, then instruction 0x20BD (MOV R1, #5) with run pulsed at edge 0 -> done=1 in the 4th cycle, d_out=0x0005, flags=000, busy=0 afterwards.
REQ-035 SHALL cover: then 0x3FE1 (ADD R1, #0xFF) -> d_out=0x0104, flags=000.
REQ-036 SHALL cover: then 0x4404 (SUB R2, R1, reg) -> d_out=0xFEFC, carry=1, zero=0, R2=0xFEFC.
REQ-037 SHALL cover: 0x0003 (fmt=3) -> done pulses, flags=100, d_out and all registers unchanged.
REQ-038 SHALL cover: run held high with 3 instructions -> exactly 3 done pulses spaced 4 cycles apart, and instruction changes mid-flight have no effect.
REQ-039 SHALL cover: reset asserted in EXEC -> no done pulse, all outputs 0, R1 reads 0 via a subsequent MOV R2, R1 (d_out=0x0000, zero=1).
